// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control block: FSM state encodings and default sizing.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned DB_BITS_DEF         = 16;
  localparam int unsigned LAP_BITS_DEF        = 4;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One button path: 2-flop synchroniser, debounce counter and rising-edge pulse.
// Flops update on the falling edge of NEclk with a synchronous active-high Reset.
module stopwatch_ctrl_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_BITS         = 16
) (
  input  logic NEclk,
  input  logic Reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam logic [DB_BITS-1:0] CNT_LAST = DB_BITS'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               level_q, level_d;
  logic               pulse_q, pulse_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;

  // Count consecutive samples that differ from the accepted level; any agreement restarts it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_BITS'(1);
      end
    end
  end

  always_ff @(negedge NEclk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop, lap freeze and clear from two debounced buttons.
// Define STOPWATCH_LAP_EN to build the LAP state and lap counter.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DB_BITS         = DB_BITS_DEF,
  parameter int unsigned LAP_BITS        = LAP_BITS_DEF
) (
  input  logic                NEclk,
  input  logic                Reset,
  input  logic                btn_start_stop,
  input  logic                btn_lap_reset,
  input  logic                count_full,
  output logic                count_enable,
  output logic                count_nreset,
  output logic                disp_hold,
  output logic [LAP_BITS-1:0] lap_count,
  output logic [1:0]          state
);

  logic      ss_p, lr_p;
  sw_state_e state_q, state_d;
  logic      clear_c;
  logic      count_enable_q, count_enable_d;
  logic      count_nreset_q, count_nreset_d;
`ifdef STOPWATCH_LAP_EN
  logic                lap_inc_c;
  logic                disp_hold_q, disp_hold_d;
  logic [LAP_BITS-1:0] lap_q, lap_d;
`endif

  stopwatch_ctrl_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_BITS         (DB_BITS)
  ) u_ss (
    .NEclk   (NEclk),
    .Reset   (Reset),
    .btn_i   (btn_start_stop),
    .pulse_o (ss_p)
  );

  stopwatch_ctrl_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_BITS         (DB_BITS)
  ) u_lr (
    .NEclk   (NEclk),
    .Reset   (Reset),
    .btn_i   (btn_lap_reset),
    .pulse_o (lr_p)
  );

  // Next state; priority is count_full, then ss_p, then lr_p (lr_p dropped when ss_p coincides).
  always_comb begin
    state_d = state_q;
    clear_c = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_inc_c = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ss_p) begin
          state_d = ST_RUN;
        end else if (lr_p) begin
          clear_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (count_full || ss_p) begin
          state_d = ST_PAUSE;
        end
`ifdef STOPWATCH_LAP_EN
        else if (lr_p) begin
          state_d   = ST_LAP;
          lap_inc_c = 1'b1;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (count_full || ss_p) begin
          state_d = ST_PAUSE;
        end else if (lr_p) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_PAUSE: begin
        if (ss_p) begin
          if (!count_full) begin
            state_d = ST_RUN;
          end
        end else if (lr_p) begin
          state_d = ST_IDLE;
          clear_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_enable_d = (state_d == ST_RUN) || (state_d == ST_LAP);
    count_nreset_d = !clear_c;
  end

  always_ff @(negedge NEclk) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      count_enable_q <= 1'b0;
      count_nreset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_enable_q <= count_enable_d;
      count_nreset_q <= count_nreset_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap counter saturates at all-ones; clear wins over increment.
  always_comb begin
    disp_hold_d = (state_d == ST_LAP);
    lap_d       = lap_q;
    if (clear_c) begin
      lap_d = '0;
    end else if (lap_inc_c && (lap_q != {LAP_BITS{1'b1}})) begin
      lap_d = lap_q + LAP_BITS'(1);
    end
  end

  always_ff @(negedge NEclk) begin
    if (Reset) begin
      disp_hold_q <= 1'b0;
      lap_q       <= '0;
    end else begin
      disp_hold_q <= disp_hold_d;
      lap_q       <= lap_d;
    end
  end

  assign disp_hold = disp_hold_q;
  assign lap_count = lap_q;
`else
  assign disp_hold = 1'b0;
  assign lap_count = '0;
`endif

  assign count_enable = count_enable_q;
  assign count_nreset = count_nreset_q;
  assign state        = state_q;

endmodule
